// File: rtl/sb_pkg.sv
// Shared types and constants for the register scoreboard.
// Optional macro SB_WAW_STALL_EN is consumed by reg_scoreboard.sv.
package sb_pkg;

  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned REG_IDX_W    = 5;
  localparam int unsigned REG_SPACE    = 32;  // addressable by a 5-bit index
  localparam int unsigned STALL_W      = 16;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/sb_reg_counter.sv
// One saturating pending-write counter: +1 on issue, -1/-2 on release,
// clamps at zero and flags the release that overran it.
module sb_reg_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_dec2,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_underflow_c
);

  localparam int unsigned     SUM_W = CNT_W + 2;
  localparam logic [SUM_W-1:0] MAX_S = SUM_W'((1 << CNT_W) - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [SUM_W-1:0] w_sum;
  logic [SUM_W-1:0] w_sub;
  logic [SUM_W-1:0] w_diff;
  logic [CNT_W-1:0] w_next;

  // Net update evaluated wide enough that +1 and -2 never wrap.
  always_comb begin
    w_sum         = SUM_W'(r_cnt) + SUM_W'(i_inc);
    w_sub         = i_dec2 ? SUM_W'(2) : SUM_W'(i_dec);
    w_diff        = w_sum - w_sub;
    o_underflow_c = (w_sub > w_sum);
    w_next        = r_cnt;
    if (o_underflow_c) begin
      w_next = '0;
    end else if (w_diff > MAX_S) begin
      w_next = CNT_W'(MAX_S);
    end else begin
      w_next = CNT_W'(w_diff);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_next;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters gating issue.
// Define SB_WAW_STALL_EN to limit each register to one outstanding writer.
module reg_scoreboard
  import sb_pkg::*;
#(
  parameter int unsigned CNT_W    = 2,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic [4:0]          issue_rs,
  input  logic [4:0]          issue_rt,
  input  logic                issue_uses_rs,
  input  logic                issue_uses_rt,
  input  logic                issue_writes,
  input  logic [4:0]          issue_rd,
  output logic                issue_ready,
  input  logic                wb_valid,
  input  logic [4:0]          wb_reg,
  input  logic                kill_valid,
  input  logic [4:0]          kill_reg,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [15:0]         stall_count,
  output logic                underflow_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]     w_cnt [REG_SPACE];
  logic [REG_SPACE-1:0] w_uf;
  logic                 w_accept;
  logic                 w_rs_haz;
  logic                 w_rt_haz;
  logic                 w_rd_full;
  logic                 w_waw_haz;
  logic [STALL_W-1:0]   r_stall_count;
  logic                 r_underflow_err;

  // Count after a same-cycle writeback is nonzero.
  function automatic logic eff_nz(input logic [CNT_W-1:0] c, input logic wb_hit);
    return (c > CNT_W'(1)) || ((c == CNT_W'(1)) && !wb_hit);
  endfunction

  // Issue gate; untracked registers read back a zero count so never hazard.
  always_comb begin
    w_rs_haz  = issue_uses_rs &&
                eff_nz(w_cnt[issue_rs], wb_valid && (wb_reg == issue_rs));
    w_rt_haz  = issue_uses_rt &&
                eff_nz(w_cnt[issue_rt], wb_valid && (wb_reg == issue_rt));
    w_rd_full = issue_writes && (w_cnt[issue_rd] == CNT_MAX);
`ifdef SB_WAW_STALL_EN
    w_waw_haz = issue_writes && (issue_rd != REG_ZERO) &&
                eff_nz(w_cnt[issue_rd], wb_valid && (wb_reg == issue_rd));
`else
    w_waw_haz = 1'b0;
`endif
    issue_ready = !(w_rs_haz || w_rt_haz || w_rd_full || w_waw_haz);
  end

  assign w_accept = issue_valid && issue_ready;

  for (genvar gi = 0; gi < REG_SPACE; gi++) begin : g_reg
    if ((gi == 0) || (gi >= NUM_REGS)) begin : g_untracked
      assign w_cnt[gi] = '0;
      assign w_uf[gi]  = 1'b0;
    end else begin : g_tracked
      logic w_inc;
      logic w_wb;
      logic w_kill;

      assign w_inc  = w_accept && issue_writes && (issue_rd == reg_idx_t'(gi));
      assign w_wb   = wb_valid && (wb_reg == reg_idx_t'(gi));
      assign w_kill = kill_valid && (kill_reg == reg_idx_t'(gi));

      sb_reg_counter #(
        .CNT_W(CNT_W)
      ) u_cnt (
        .clk          (clk),
        .rst          (rst),
        .i_inc        (w_inc),
        .i_dec        (w_wb ^ w_kill),
        .i_dec2       (w_wb & w_kill),
        .o_cnt        (w_cnt[gi]),
        .o_underflow_c(w_uf[gi])
      );
    end
  end

  for (genvar gb = 0; gb < NUM_REGS; gb++) begin : g_busy
    assign busy_mask[gb] = |w_cnt[gb];
  end

  // Saturating stall counter and sticky underflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_count   <= '0;
      r_underflow_err <= 1'b0;
    end else begin
      if (issue_valid && !issue_ready && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + STALL_W'(1);
      end
      if (|w_uf) begin
        r_underflow_err <= 1'b1;
      end
    end
  end

  assign stall_count   = r_stall_count;
  assign underflow_err = r_underflow_err;

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 The block SHALL have parameter CNT_W, default 2, width of each per-register pending-write counter (max outstanding = 2^CNT_W-1).
REQ-002 The block SHALL have parameter NUM_REGS, default 32, number of architectural registers tracked.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 issue_valid  in  1  decode stage presents an instruction.
REQ-006 issue_rs, issue_rt  in  5 each  source register indices.
REQ-007 issue_uses_rs, issue_uses_rt  in  1 each  source actually read.
REQ-008 issue_writes  in  1  instruction writes a register; issue_rd  in  5  destination index.
REQ-009 issue_ready  out  1  instruction may issue this cycle.
REQ-010 wb_valid  in  1  writeback completes; wb_reg  in  5  register written.
REQ-011 kill_valid  in  1  an issued writer was squashed; kill_reg  in  5  its destination.
REQ-012 busy_mask  out  NUM_REGS  bit i = register i has a pending write.
REQ-013 stall_count  out  16  cycles with issue_valid && !issue_ready.
REQ-014 underflow_err  out  1  sticky: release seen with counter already 0.

Function
REQ-015 Register 0 SHALL never be tracked: counter forced 0, never a hazard, writes to it ignored.
REQ-016 Per register i, eff_cnt[i] = cnt[i] minus same-cycle wb decrement (wb_valid && wb_reg==i ? 1 : 0), floored at 0.
REQ-017 issue_ready SHALL be 0 if issue_uses_rs && eff_cnt[rs]!=0, or issue_uses_rt && eff_cnt[rt]!=0, or issue_writes && cnt[rd]==max; else 1 (combinational, same-cycle writeback releases RAW hazard).
REQ-018 Issue SHALL be accepted when issue_valid && issue_ready; if issue_writes && rd!=0, cnt[rd] increments at that edge.
REQ-019 wb_valid SHALL decrement cnt[wb_reg] by 1; kill_valid SHALL decrement cnt[kill_reg] by 1.
REQ-020 Same-register net update per edge = +issue -wb -kill; issue+wb on same reg leaves count unchanged.
REQ-021 If a net decrement exceeds the current count, counter SHALL clamp to 0 and underflow_err SHALL set.
REQ-022 Counters SHALL never exceed max; REQ-017 guarantees this.
REQ-023 busy_mask SHALL reflect registered counters (updates visible one cycle after issue/wb/kill).
REQ-024 stall_count SHALL increment each cycle issue_valid && !issue_ready, saturating at 16'hFFFF.
REQ-025 issue_ready SHALL be independent of issue_valid (valid-before-ready not required).

Reset
REQ-026 rst SHALL immediately clear all counters, busy_mask=0, stall_count=0, underflow_err=0; issue_ready is then 1 for any input.
REQ-027 Reset mid-operation SHALL discard all pending writes; subsequent wb for them SHALL set underflow_err.

Configuration
REQ-028 Macro SB_WAW_STALL_EN: when defined, issue_ready SHALL also be 0 if issue_writes && rd!=0 && eff_cnt[rd]!=0 (at most one outstanding writer per register).
REQ-029 Without SB_WAW_STALL_EN, multiple outstanding writers per register SHALL be allowed up to counter max.

Structure
REQ-030 Package sb_pkg SHALL hold NUM_REGS default, reg_idx_t (5-bit typedef), REG_ZERO constant, stall counter width.
REQ-031 Sub-module sb_reg_counter (one saturating up/down counter with inc, dec, dec2, underflow flag) SHALL be instantiated per register 1..NUM_REGS-1.

Verification
REQ-032 Issue writer rd=8, next cycle issue reader rs=8 -> issue_ready=0, stall_count=1; wb_reg=8 same cycle as retry -> issue_ready=1.
REQ-033 Issue three writers to rd=5 (CNT_W=2) -> busy_mask[5]=1, fourth writer to rd=5 stalls; one wb -> fourth accepted.
REQ-034 Issue writer rd=0 then reader rs=0 -> no stall, busy_mask=0.
REQ-035 wb_reg=9 with cnt[9]=0 -> underflow_err=1, remains 1 until rst.
REQ-036 Same-cycle issue rd=7, wb 7, with cnt[7]=1 -> cnt[7] stays 1; kill 7 plus wb 7 with cnt=2 -> cnt=0, no error.
REQ-037 With SB_WAW_STALL_EN: writer rd=6 pending, second writer rd=6 -> issue_ready=0; without macro -> issue_ready=1.
